// File: rtl/regfile_pkg.sv
// Shared constants and address-legality helper for the multi-port register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

   localparam int unsigned REG_ZERO       = 0;
   localparam int          DATA_W_DEFAULT = 32;
   localparam int          ADDR_W_DEFAULT = 5;

   // An address is usable when it maps to a real register and is not the hard-wired zero register
   function automatic logic addr_valid(input int unsigned addr,
                                       input int unsigned num_regs,
                                       input bit          zero_reg);
      return (addr < num_regs) && !(zero_reg && (addr == REG_ZERO));
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-side bundle of the register file: read ports, two write ports, reservation.
// Latency: n/a (wiring only).
// Backpressure: none; the busy flags are the only hazard signal and are advisory to issue logic.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr0_en;
   logic [ADDR_W-1:0]        wr0_addr;
   logic [DATA_W-1:0]        wr0_data;
   logic                     wr1_en;
   logic [ADDR_W-1:0]        wr1_addr;
   logic [DATA_W-1:0]        wr1_data;
   logic                     resv_en;
   logic [ADDR_W-1:0]        resv_addr;

   modport master (
      output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, resv_en, resv_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, resv_en, resv_addr,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/rf_read_port.sv
// One read port: same-cycle write bypass (load port wins) and busy masking for bypassed operands.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; illegal addresses and reset force data 0 and busy 0.
module rf_read_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              i_rst,
   input  logic              i_addr_ok,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic [DATA_W-1:0] i_arr_data,
   input  logic              i_arr_busy,
   input  logic              i_wr0_en,
   input  logic [ADDR_W-1:0] i_wr0_addr,
   input  logic [DATA_W-1:0] i_wr0_data,
   input  logic              i_wr1_en,
   input  logic [ADDR_W-1:0] i_wr1_addr,
   input  logic [DATA_W-1:0] i_wr1_data,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_busy
);

   logic w_hit0;
   logic w_hit1;

   assign w_hit0 = i_wr0_en && (i_wr0_addr == i_rd_addr);
   assign w_hit1 = i_wr1_en && (i_wr1_addr == i_rd_addr);

   // Pick the freshest value; a write in flight also means the operand is no longer waiting
   always_comb begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
      if (!i_rst && i_addr_ok) begin
         if (w_hit1)
            o_rd_data = i_wr1_data;
         else if (w_hit0)
            o_rd_data = i_wr0_data;
         else
            o_rd_data = i_arr_data;
         o_rd_busy = i_arr_busy && !(w_hit0 || w_hit1);
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, two write ports (wr1 wins), busy scoreboard.
// Latency: reads 0 cycles (writes visible same cycle via bypass); writes/reservations land at the clk edge.
// Backpressure: none; rd_busy tells issue logic to stall, the file itself never refuses a write.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int ADDR_W   = ADDR_W_DEFAULT,
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);

   // Storage covers the full address space so any address indexes safely; rows at or above
   // NUM_REGS (and row 0 when hard-wired) are never written and stay at their reset value.
   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0][DATA_W-1:0] r_mem;
   logic [DEPTH-1:0]             r_busy;

   logic w_wr0_ok;
   logic w_wr1_ok;
   logic w_resv_ok;

   assign w_wr0_ok  = bus.wr0_en  && addr_valid(32'(bus.wr0_addr),  NUM_REGS, ZERO_REG != 0);
   assign w_wr1_ok  = bus.wr1_en  && addr_valid(32'(bus.wr1_addr),  NUM_REGS, ZERO_REG != 0);
   assign w_resv_ok = bus.resv_en && addr_valid(32'(bus.resv_addr), NUM_REGS, ZERO_REG != 0);

   // Register array and scoreboard update: wr1 over wr0 for data, reservation over write for busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem  <= '0;
         r_busy <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr1_ok && (bus.wr1_addr == ADDR_W'(i)))
               r_mem[i] <= bus.wr1_data;
            else if (w_wr0_ok && (bus.wr0_addr == ADDR_W'(i)))
               r_mem[i] <= bus.wr0_data;

            if (w_resv_ok && (bus.resv_addr == ADDR_W'(i)))
               r_busy[i] <= 1'b1;
            else if ((w_wr1_ok && (bus.wr1_addr == ADDR_W'(i))) ||
                     (w_wr0_ok && (bus.wr0_addr == ADDR_W'(i))))
               r_busy[i] <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_ok;

      assign w_addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
      assign w_ok   = addr_valid(32'(w_addr), NUM_REGS, ZERO_REG != 0);

      rf_read_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_rd (
         .i_rst      (rst),
         .i_addr_ok  (w_ok),
         .i_rd_addr  (w_addr),
         .i_arr_data (r_mem[w_addr]),
         .i_arr_busy (r_busy[w_addr]),
         .i_wr0_en   (bus.wr0_en),
         .i_wr0_addr (bus.wr0_addr),
         .i_wr0_data (bus.wr0_data),
         .i_wr1_en   (bus.wr1_en),
         .i_wr1_addr (bus.wr1_addr),
         .i_wr1_data (bus.wr1_data),
         .o_rd_data  (bus.rd_data[k*DATA_W +: DATA_W]),
         .o_rd_busy  (bus.rd_busy[k])
      );
   end

endmodule
